// File: rtl/base_mem_rdarb.sv
// base_mem_rdarb: round-robin arbiter that shares one synchronous-read memory
// port among n requesters. Each requester owns a one-entry response slot
// (EMPTY -> PEND -> FULL). Read data is returned two cycles after the grant.
module base_mem_rdarb #(
  parameter int width      = 1,
  parameter int addr_width = 1,
  parameter int n          = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [n-1:0]              i_r_v,
  output logic [n-1:0]              i_r_r,
  input  logic [n*addr_width-1:0]   i_r_a,
  output logic                      o_re,
  output logic [addr_width-1:0]     o_ra,
  input  logic [width-1:0]          i_rd,
  output logic [n-1:0]              o_d_v,
  input  logic [n-1:0]              i_d_r,
  output logic [n*width-1:0]        o_d_d
);

  localparam int PW = (n > 1) ? $clog2(n) : 1;

  typedef enum logic [1:0] {
    SLOT_EMPTY = 2'd0,
    SLOT_PEND  = 2'd1,
    SLOT_FULL  = 2'd2
  } slot_e;

  slot_e                 slot_r [n];
  logic [PW-1:0]         last_r;     // index of the most recently granted requester
  logic [n-1:0]          elig_s;
  logic [n-1:0]          grant_s;
  logic [PW-1:0]         gidx_s;
  logic                  any_s;
  logic [addr_width-1:0] ra_s;

  // A requester may be granted if its slot is free, or is being drained this cycle.
  always_comb begin
    elig_s = '0;
    for (int k = 0; k < n; k++) begin
      if (!reset) begin
        elig_s[k] = 1'b0;
      end else if (i_r_v[k] &&
                   ((slot_r[k] == SLOT_EMPTY) ||
                    ((slot_r[k] == SLOT_FULL) && i_d_r[k]))) begin
        elig_s[k] = 1'b1;
      end else begin
        elig_s[k] = 1'b0;
      end
    end
  end

  // Round-robin pick: scan starting just after the last granted requester.
  always_comb begin
    grant_s = '0;
    gidx_s  = '0;
    any_s   = 1'b0;
    ra_s    = '0;
    for (int off = 1; off <= n; off++) begin
      for (int k = 0; k < n; k++) begin
        if (!any_s && elig_s[k] && (k == ((int'(last_r) + off) % n))) begin
          any_s      = 1'b1;
          grant_s[k] = 1'b1;
          gidx_s     = PW'(k);
          ra_s       = i_r_a[k*addr_width +: addr_width];
        end else begin
          any_s = any_s;
        end
      end
    end
  end

  assign i_r_r = grant_s;
  assign o_re  = any_s;
  assign o_ra  = ra_s;

  // Response valid is simply "slot holds data".
  always_comb begin
    o_d_v = '0;
    for (int k = 0; k < n; k++) begin
      o_d_v[k] = (slot_r[k] == SLOT_FULL);
    end
  end

  // Slot state machine, response data capture and round-robin pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < n; k++) begin
        slot_r[k] <= SLOT_EMPTY;
      end
      o_d_d  <= '0;
      last_r <= PW'(n - 1);   // makes requester 0 the first in line
    end else begin
      if (any_s) begin
        last_r <= gidx_s;
      end
      for (int k = 0; k < n; k++) begin
        case (slot_r[k])
          SLOT_EMPTY: begin
            if (grant_s[k]) begin
              slot_r[k] <= SLOT_PEND;
            end
          end
          SLOT_PEND: begin
            // memory data is valid exactly one cycle after the grant
            slot_r[k]                <= SLOT_FULL;
            o_d_d[k*width +: width]  <= i_rd;
          end
          SLOT_FULL: begin
            if (grant_s[k]) begin
              slot_r[k] <= SLOT_PEND;
            end else if (i_d_r[k]) begin
              slot_r[k] <= SLOT_EMPTY;
            end
          end
          default: begin
            slot_r[k] <= SLOT_EMPTY;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_base_mem_rdarb.sv
// Randomized bench for base_mem_rdarb with a transaction-level reference model
// of the slots, the round-robin order and a behavioural memory.
module tb_base_mem_rdarb;

  localparam int W  = 8;
  localparam int AW = 4;
  localparam int N  = 4;

  localparam int EMPTY = 0;
  localparam int PEND  = 1;
  localparam int FULL  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      i_r_v;
  logic [N-1:0]      i_r_r;
  logic [N*AW-1:0]   i_r_a;
  logic              o_re;
  logic [AW-1:0]     o_ra;
  logic [W-1:0]      i_rd;
  logic [N-1:0]      o_d_v;
  logic [N-1:0]      i_d_r;
  logic [N*W-1:0]    o_d_d;

  base_mem_rdarb #(.width(W), .addr_width(AW), .n(N)) dut (
    .clk   (clk),
    .reset (reset),
    .i_r_v (i_r_v),
    .i_r_r (i_r_r),
    .i_r_a (i_r_a),
    .o_re  (o_re),
    .o_ra  (o_ra),
    .i_rd  (i_rd),
    .o_d_v (o_d_v),
    .i_d_r (i_d_r),
    .o_d_d (o_d_d)
  );

  always #5 clk = ~clk;

  // reference model state
  int           st   [N];
  logic [W-1:0] dat  [N];
  logic [W-1:0] mem  [16];
  int           last;
  logic         rd_pend;
  logic [AW-1:0] rd_addr;

  int n_vec;
  int n_bad;

  logic [N-1:0]   smp_gnt;
  logic [N-1:0]   smp_dv;
  logic [N*W-1:0] smp_dd;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      st[k]  = EMPTY;
      dat[k] = '0;
    end
    last    = N - 1;
    rd_pend = 1'b0;
  endtask

  // One clock cycle: drive at negedge, check, then advance the model at posedge.
  task automatic run_cycle(input logic [N-1:0] v, input logic [N*AW-1:0] a,
                           input logic [N-1:0] dr, input logic rst);
    int             g;
    logic [N-1:0]   exp_gnt;
    logic [N-1:0]   exp_v;
    logic [N*W-1:0] exp_dd;
    logic [AW-1:0]  exp_ra;
    @(negedge clk);
    i_r_v = v;
    i_r_a = a;
    i_d_r = dr;
    reset = rst;
    i_rd  = rd_pend ? mem[rd_addr] : W'($urandom);
    if (!rst) model_reset();
    g = -1;
    if (rst) begin
      for (int off = 1; off <= N; off++) begin
        int k;
        k = (last + off) % N;
        if (g < 0 && v[k] && (st[k] == EMPTY || (st[k] == FULL && dr[k]))) g = k;
      end
    end
    exp_gnt = '0;
    exp_ra  = '0;
    if (g >= 0) begin
      exp_gnt[g] = 1'b1;
      exp_ra     = a[g*AW +: AW];
    end
    for (int k = 0; k < N; k++) begin
      exp_v[k]         = (st[k] == FULL);
      exp_dd[k*W +: W] = dat[k];
    end
    #1;
    check_val("i_r_r", 64'(i_r_r), 64'(exp_gnt));
    check_val("o_re",  64'(o_re),  64'(g >= 0));
    check_val("o_ra",  64'(o_ra),  64'(exp_ra));
    check_val("o_d_v", 64'(o_d_v), 64'(exp_v));
    check_val("o_d_d", 64'(o_d_d), 64'(exp_dd));
    smp_gnt = i_r_r;
    smp_dv  = o_d_v;
    smp_dd  = o_d_d;
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        if (st[k] == PEND) begin
          st[k]  = FULL;
          dat[k] = i_rd;
        end else if (k == g) begin
          st[k] = PEND;
        end else if (st[k] == FULL && dr[k]) begin
          st[k] = EMPTY;
        end
      end
      rd_pend = (g >= 0);
      if (g >= 0) begin
        rd_addr = a[g*AW +: AW];
        last    = g;
      end
    end
  endtask

  initial begin
    logic [N*AW-1:0] ra;
    logic [W-1:0]    hold_d;
    n_vec = 0;
    n_bad = 0;
    for (int i = 0; i < 16; i++) mem[i] = W'($urandom);
    mem[5] = 8'hA5;
    reset = 1'b0;
    i_r_v = '0;
    i_r_a = '0;
    i_d_r = '0;
    i_rd  = '0;
    model_reset();

    // held in reset with everything requesting: nothing may be granted
    run_cycle(4'b1111, 16'hFFFF, 4'b1111, 1'b0);
    run_cycle(4'b1111, 16'h1234, 4'b1111, 1'b0);

    // single read of address 5 right after reset release
    run_cycle(4'b0001, 16'h0005, 4'b1111, 1'b1);
    check_val("rd5_gnt", 64'(smp_gnt), 64'(4'b0001));
    run_cycle(4'b0000, 16'h0000, 4'b1111, 1'b1);
    run_cycle(4'b0000, 16'h0000, 4'b1111, 1'b1);
    check_val("rd5_dv", 64'(smp_dv), 64'(4'b0001));
    check_val("rd5_dd", 64'(smp_dd[7:0]), 64'(8'hA5));
    run_cycle(4'b0000, 16'h0000, 4'b1111, 1'b1);
    check_val("rd5_dv_off", 64'(smp_dv), 64'(4'b0000));

    // two always-valid requesters alternate 0,1,0,1 from reset
    run_cycle(4'b0000, 16'h0000, 4'b1111, 1'b0);
    for (int i = 0; i < 6; i++) begin
      run_cycle(4'b0011, 16'h0021, 4'b1111, 1'b1);
      check_val("alt_gnt", 64'(smp_gnt), (i % 2 == 0) ? 64'(4'b0001) : 64'(4'b0010));
    end

    // requester 0 stalls its response; 1 keeps reading, slot 0 data frozen
    run_cycle(4'b0011, 16'h0043, 4'b0000, 1'b1);
    run_cycle(4'b0011, 16'h0043, 4'b0000, 1'b1);
    hold_d = smp_dd[7:0];
    for (int i = 0; i < 5; i++) begin
      run_cycle(4'b0011, 16'h0043, 4'b0000, 1'b1);
      check_val("hold_no_g0", 64'(smp_gnt[0]), 64'(1'b0));
      check_val("hold_dd0", 64'(smp_dd[7:0]), 64'(hold_d));
    end

    // drain and regrant slot 0 in the same cycle
    run_cycle(4'b0001, 16'h0005, 4'b0001, 1'b1);
    check_val("regrant0", 64'(smp_gnt), 64'(4'b0001));
    run_cycle(4'b0000, 16'h0000, 4'b0000, 1'b1);
    check_val("regrant_gap", 64'(smp_dv[0]), 64'(1'b0));
    run_cycle(4'b0000, 16'h0000, 4'b0000, 1'b1);
    check_val("regrant_dd", 64'(smp_dd[7:0]), 64'(8'hA5));

    // reset the cycle after a grant to requester 2; pending read is dropped
    run_cycle(4'b0000, 16'h0000, 4'b1111, 1'b0);
    run_cycle(4'b0100, 16'h0700, 4'b1111, 1'b1);
    check_val("g2", 64'(smp_gnt), 64'(4'b0100));
    run_cycle(4'b0000, 16'h0000, 4'b1111, 1'b0);
    run_cycle(4'b0000, 16'h0000, 4'b1111, 1'b1);
    check_val("rst_nodv_a", 64'(smp_dv), 64'(4'b0000));
    run_cycle(4'b0000, 16'h0000, 4'b1111, 1'b1);
    check_val("rst_nodv_b", 64'(smp_dv), 64'(4'b0000));
    run_cycle(4'b0000, 16'h0000, 4'b1111, 1'b0);
    run_cycle(4'b1010, 16'h9191, 4'b1111, 1'b1);
    check_val("post_rst_g1", 64'(smp_gnt), 64'(4'b0010));

    // randomized traffic, occasional reset pulses
    for (int i = 0; i < 800; i++) begin
      ra = (N*AW)'($urandom);
      run_cycle(N'($urandom), ra, N'($urandom), ($urandom_range(0, 79) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/base_mem_rdarb.md
BASE_MEM_RDARB -- requirements
Module: base_mem_rdarb

Interface
REQ-001 SHALL have parameter width, default 1, meaning data bits per memory word.
REQ-002 SHALL have parameter addr_width, default 1, meaning memory address bits.
REQ-003 SHALL have parameter n, default 2, meaning number of read requesters; legal range 2..8.
REQ-004 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  meaning the asynchronous, active-low reset.
REQ-006 SHALL have port i_r_v  input  n  meaning per-requester read-request valid.
REQ-007 SHALL have port i_r_r  output  n  meaning per-requester read-request accepted (grant).
REQ-008 SHALL have port i_r_a  input  n*addr_width  meaning per-requester read address; requester k uses slice k.
REQ-009 SHALL have port o_re  output  1  meaning memory read enable.
REQ-010 SHALL have port o_ra  output  addr_width  meaning memory read address.
REQ-011 SHALL have port i_rd  input  width  meaning memory read data, valid the cycle after o_re.
REQ-012 SHALL have port o_d_v  output  n  meaning per-requester response valid.
REQ-013 SHALL have port i_d_r  input  n  meaning per-requester response ready.
REQ-014 SHALL have port o_d_d  output  n*width  meaning per-requester response data; slice k for requester k.

Function
REQ-015 SHALL keep a per-requester slot state: EMPTY, PEND (read issued, data on i_rd this cycle) or FULL (data held).
REQ-016 SHALL treat requester k as eligible when i_r_v[k]=1 and slot k is EMPTY, or slot k is FULL with i_d_r[k]=1 in the same cycle.
REQ-017 SHALL grant at most one eligible requester per cycle by round-robin; the requester after the last granted one has highest priority, wrapping from n-1 to 0.
REQ-018 SHALL drive i_r_r combinationally: one-hot on the granted requester, all zero when no requester is eligible.
REQ-019 SHALL drive o_re = OR of grants and o_ra = i_r_a slice of the granted requester, combinationally in the grant cycle; o_ra is 0 when o_re=0.
REQ-020 SHALL move slot k to PEND at the grant edge, from PEND to FULL unconditionally on the next edge, capturing i_rd into o_d_d slice k.
REQ-021 SHALL move slot k from FULL to EMPTY when i_d_r[k]=1 and no new grant to k; to PEND when drained and regranted in the same cycle.
REQ-022 SHALL drive o_d_v[k]=1 exactly while slot k is FULL; o_d_d slice k SHALL be stable while o_d_v[k]=1 and i_d_r[k]=0.
REQ-023 SHALL give request-to-response latency of 2 cycles: grant in cycle t, o_d_v in cycle t+2.
REQ-024 SHALL ignore i_d_r[k] when slot k is not FULL, and ignore i_rd when no slot is PEND.
REQ-025 SHALL sustain one memory read per cycle aggregate; per-requester maximum is one read per 2 cycles.
REQ-026 SHALL advance the round-robin pointer only on cycles with a grant.

Reset
REQ-027 SHALL, while reset=0, force all slots EMPTY, o_d_v=0, o_d_d=0, round-robin pointer to give requester 0 highest priority, and i_r_r=0, o_re=0, o_ra=0.
REQ-028 SHALL, on reset asserted with a slot in PEND, discard the pending data; no o_d_v is produced for it after reset release.
REQ-029 SHALL accept requests in the first cycle after reset deasserts.

Verification
REQ-030 SHALL cover: width=8, mem[5]=0xA5, requester 0 requests addr 5 in cycle t with i_d_r=1 -> i_r_r[0]=1, o_re=1, o_ra=5 in t; o_d_v[0]=1, o_d_d[7:0]=0xA5 in t+2 for one cycle.
REQ-031 SHALL cover: requesters 0 and 1 both continuously valid, ready always 1, first cycle after reset -> grant order 0,1,0,1,...; o_re=1 every cycle.
REQ-032 SHALL cover: requester 0 response held with i_d_r[0]=0 for 5 cycles while both request -> requester 0 not granted, requester 1 granted every other cycle, o_d_d slice 0 unchanged.
REQ-033 SHALL cover: slot 0 FULL, i_d_r[0]=1 and i_r_v[0]=1 in same cycle, requester 1 idle -> i_r_r[0]=1 that cycle; o_d_v[0] low one cycle, then high with new data.
REQ-034 SHALL cover: reset asserted in the cycle after a grant to requester 2 (n=4) -> o_d_v all 0 during and after reset; first post-reset simultaneous requests on 1 and 3 -> requester 1 granted first.
